// File: rtl/md_sched_pkg.sv
// Shared op encoding and decode helpers for the HI/LO multiply-divide scheduler.
// MD_SCHED_MADD_EN enables the madd/maddu/msub/msubu start class.
package md_pkg;

  localparam logic [3:0] MD_NONE = 4'd0;
  localparam logic [3:0] MULT    = 4'd1;
  localparam logic [3:0] MULTU   = 4'd2;
  localparam logic [3:0] DIV     = 4'd3;
  localparam logic [3:0] DIVU    = 4'd4;
  localparam logic [3:0] MTHI    = 4'd5;
  localparam logic [3:0] MTLO    = 4'd6;
  localparam logic [3:0] MFHI    = 4'd7;
  localparam logic [3:0] MFLO    = 4'd8;
  localparam logic [3:0] MADD    = 4'd9;
  localparam logic [3:0] MADDU   = 4'd10;
  localparam logic [3:0] MSUB    = 4'd11;
  localparam logic [3:0] MSUBU   = 4'd12;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } md_state_e;

  function automatic logic is_md_start(input logic [3:0] op);
    logic start_s;
    case (op)
      MULT, MULTU, DIV, DIVU: start_s = 1'b1;
`ifdef MD_SCHED_MADD_EN
      MADD, MADDU, MSUB, MSUBU: start_s = 1'b1;
`endif
      default: start_s = 1'b0;
    endcase
    return start_s;
  endfunction

endpackage

// File: rtl/md_sched_calc.sv
// Combinational HI/LO arithmetic: products, quotient/remainder and accumulate forms.
// MD_SCHED_MADD_EN adds the {HI,LO} +/- product forms.
module md_calc
  import md_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] rs,
  input  logic [31:0] rt,
  input  logic [31:0] hi,
  input  logic [31:0] lo,
  output logic [63:0] result,
  output logic        div_zero
);

  logic signed [63:0] sprod_s;
  logic        [63:0] uprod_s;
  logic signed [32:0] sdivd_s;
  logic signed [32:0] sdivs_s;
  logic        [31:0] squot_s;
  logic        [31:0] srem_s;
  logic        [31:0] udivs_s;
  logic               rt_zero_s;

  assign rt_zero_s = (rt == 32'd0);
  assign sprod_s   = $signed({{32{rs[31]}}, rs}) * $signed({{32{rt[31]}}, rt});
  assign uprod_s   = {32'd0, rs} * {32'd0, rt};

  // 33-bit signed divide keeps 0x80000000 / -1 from overflowing; the zero divisor is masked.
  assign sdivd_s = $signed({rs[31], rs});
  assign sdivs_s = rt_zero_s ? 33'sd1 : $signed({rt[31], rt});
  assign squot_s = 32'(sdivd_s / sdivs_s);
  assign srem_s  = 32'(sdivd_s % sdivs_s);
  assign udivs_s = rt_zero_s ? 32'd1 : rt;

  // Select the 64-bit result for the operation presented in E.
  always_comb begin
    result   = {hi, lo};
    div_zero = 1'b0;
    case (op)
      MULT:  result = sprod_s;
      MULTU: result = uprod_s;
      DIV: begin
        result   = {srem_s, squot_s};
        div_zero = rt_zero_s;
      end
      DIVU: begin
        result   = {rs % udivs_s, rs / udivs_s};
        div_zero = rt_zero_s;
      end
`ifdef MD_SCHED_MADD_EN
      MADD:  result = {hi, lo} + sprod_s;
      MADDU: result = {hi, lo} + uprod_s;
      MSUB:  result = {hi, lo} - sprod_s;
      MSUBU: result = {hi, lo} - uprod_s;
`endif
      default: result = {hi, lo};
    endcase
  end

endmodule

// File: rtl/md_sched.sv
// HI/LO multiply-divide scheduler: fixed-latency busy window, pending result, D-stage stall.
// MD_SCHED_MADD_EN enables the madd-class start ops.
module md_sched
  import md_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  e_md_op,
  input  logic [31:0] e_rs,
  input  logic [31:0] e_rt,
  input  logic        d_md_use,
  output logic        md_busy,
  output logic        md_stall,
  output logic [31:0] md_hi,
  output logic [31:0] md_lo
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  md_state_e          state_r;
  logic [CNT_W-1:0]   cnt_r;
  logic [63:0]        pend_r;
  logic               pend_upd_r;
  logic [31:0]        hi_r;
  logic [31:0]        lo_r;
  logic [63:0]        calc_result_s;
  logic               calc_div_zero_s;
  logic               e_start_s;
  logic               e_div_s;
  logic [CNT_W-1:0]   start_cnt_s;

  md_calc u_calc (
    .op       (e_md_op),
    .rs       (e_rs),
    .rt       (e_rt),
    .hi       (hi_r),
    .lo       (lo_r),
    .result   (calc_result_s),
    .div_zero (calc_div_zero_s)
  );

  assign e_start_s   = is_md_start(e_md_op);
  assign e_div_s     = (e_md_op == DIV) || (e_md_op == DIVU);
  assign start_cnt_s = e_div_s ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);

  // Busy sequencing; HI/LO ops seen in E while busy are dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      cnt_r      <= {CNT_W{1'b0}};
      pend_r     <= 64'd0;
      pend_upd_r <= 1'b0;
      hi_r       <= 32'd0;
      lo_r       <= 32'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (e_start_s) begin
            state_r    <= ST_BUSY;
            cnt_r      <= start_cnt_s;
            pend_r     <= calc_result_s;
            pend_upd_r <= ~calc_div_zero_s;
          end else if (e_md_op == MTHI) begin
            hi_r <= e_rs;
          end else if (e_md_op == MTLO) begin
            lo_r <= e_rs;
          end
        end
        ST_BUSY: begin
          if (cnt_r == CNT_W'(1)) begin
            state_r <= ST_IDLE;
            cnt_r   <= {CNT_W{1'b0}};
            if (pend_upd_r) begin
              hi_r <= pend_r[63:32];
              lo_r <= pend_r[31:0];
            end
          end else begin
            cnt_r <= cnt_r - CNT_W'(1);
          end
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end

  assign md_busy  = (state_r == ST_BUSY);
  assign md_stall = d_md_use & (md_busy | e_start_s);
  assign md_hi    = hi_r;
  assign md_lo    = lo_r;

endmodule

// File: tb/tb_md_sched.sv
// Randomized scoreboard bench for md_sched against a behavioural HI/LO model.
module tb_md_sched;
  import md_pkg::*;

  logic        clk;
  logic        reset;
  logic [3:0]  e_md_op;
  logic [31:0] e_rs;
  logic [31:0] e_rt;
  logic        d_md_use;
  logic        md_busy;
  logic        md_stall;
  logic [31:0] md_hi;
  logic [31:0] md_lo;

  md_sched #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .e_md_op(e_md_op), .e_rs(e_rs), .e_rt(e_rt),
    .d_md_use(d_md_use), .md_busy(md_busy), .md_stall(md_stall),
    .md_hi(md_hi), .md_lo(md_lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          dur;
  } exp_t;

  exp_t        exp_q[$];
  int          total = 0;
  int          bad = 0;
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;
  logic [63:0] m_pend = 64'd0;
  bit          m_upd = 1'b0;
  int          m_left = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit m_start(input logic [3:0] op);
    bit s;
    s = (op >= 4'd1) && (op <= 4'd4);
`ifdef MD_SCHED_MADD_EN
    s = s || ((op >= 4'd9) && (op <= 4'd12));
`endif
    return s;
  endfunction

  // Architectural model of one clock edge.
  task automatic model_edge(input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt);
    longint      a, b, p;
    logic [63:0] up, res, acc;
    bit          upd;
    int          dur;
    if (m_left > 0) begin
      m_left--;
      if (m_left == 0 && m_upd) {m_hi, m_lo} = m_pend;
    end else if (m_start(op)) begin
      a   = $signed(rs);
      b   = $signed(rt);
      p   = a * b;
      up  = {32'd0, rs} * {32'd0, rt};
      acc = {m_hi, m_lo};
      upd = 1'b1;
      dur = 5;
      res = acc;
      case (op)
        MULT:  res = p;
        MULTU: res = up;
        DIV: begin
          dur = 10;
          if (rt == 32'd0) upd = 1'b0;
          else begin
            longint q, r;
            q = a / b;
            r = a % b;
            res = {r[31:0], q[31:0]};
          end
        end
        DIVU: begin
          dur = 10;
          if (rt == 32'd0) upd = 1'b0;
          else res = {rs % rt, rs / rt};
        end
        MADD:  res = acc + p;
        MADDU: res = acc + up;
        MSUB:  res = acc - p;
        MSUBU: res = acc - up;
        default: res = acc;
      endcase
      m_pend = res;
      m_upd  = upd;
      m_left = dur;
      exp_q.push_back('{hi: upd ? res[63:32] : m_hi, lo: upd ? res[31:0] : m_lo, dur: dur});
    end else if (op == MTHI) begin
      m_hi = rs;
    end else if (op == MTLO) begin
      m_lo = rs;
    end
  endtask

  // One cycle: drive at negedge+2, check stall, clock, check state at negedge+1.
  task automatic step(input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt, input logic use_d);
    e_md_op  = op;
    e_rs     = rs;
    e_rt     = rt;
    d_md_use = use_d;
    #1;
    chk("stall", {63'd0, md_stall}, {63'd0, use_d && (m_left > 0 || m_start(op))});
    @(posedge clk);
    model_edge(op, rs, rt);
    @(negedge clk);
    #1;
    chk("busy", {63'd0, md_busy}, {63'd0, m_left > 0});
    chk("hi", {32'd0, md_hi}, {32'd0, m_hi});
    chk("lo", {32'd0, md_lo}, {32'd0, m_lo});
    #1;
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    e_md_op  = MD_NONE;
    e_rs     = 32'd0;
    e_rt     = 32'd0;
    d_md_use = 1'b0;
    @(posedge clk);
    m_hi = 32'd0; m_lo = 32'd0; m_left = 0; m_upd = 1'b0;
    exp_q.delete();
    @(negedge clk);
    #1;
    chk("rst_busy", {63'd0, md_busy}, 64'd0);
    chk("rst_hi", {32'd0, md_hi}, 64'd0);
    chk("rst_lo", {32'd0, md_lo}, 64'd0);
    #1;
    reset = 1'b0;
  endtask

  task automatic idle(input int n, input logic use_d);
    for (int i = 0; i < n; i++) step(MD_NONE, $urandom, $urandom, use_d);
  endtask

  // Monitor: on each busy fall, pop the expected result and busy length.
  bit busy_prev = 1'b0;
  int busy_len = 0;
  always @(negedge clk) begin
    if (reset) begin
      busy_len = 0;
    end else if (md_busy === 1'b1) begin
      busy_len++;
    end else if (busy_prev) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("done_hi", {32'd0, md_hi}, {32'd0, e.hi});
        chk("done_lo", {32'd0, md_lo}, {32'd0, e.lo});
        chk("busy_len", 64'(busy_len), 64'(e.dur));
      end
      busy_len = 0;
    end
    busy_prev = (md_busy === 1'b1);
  end

  initial begin
    do_reset();

    step(MULT, 32'hFFFFFFFE, 32'd3, 1'b0);
    idle(5, 1'b0);
    chk("mult_hi", {32'd0, md_hi}, 64'h0000_0000_FFFF_FFFF);
    chk("mult_lo", {32'd0, md_lo}, 64'h0000_0000_FFFF_FFFA);

    step(DIVU, 32'd100, 32'd7, 1'b1);
    idle(11, 1'b1);
    chk("divu_hi", {32'd0, md_hi}, 64'd2);
    chk("divu_lo", {32'd0, md_lo}, 64'd14);

    step(DIV, 32'hFFFFFFF9, 32'd2, 1'b0);
    idle(10, 1'b0);
    chk("div_lo", {32'd0, md_lo}, 64'h0000_0000_FFFF_FFFD);
    chk("div_hi", {32'd0, md_hi}, 64'h0000_0000_FFFF_FFFF);
    step(DIV, 32'hFFFFFFF9, 32'd0, 1'b0);
    idle(10, 1'b0);
    chk("div0_lo", {32'd0, md_lo}, 64'h0000_0000_FFFF_FFFD);

    step(DIV, 32'h80000000, 32'hFFFFFFFF, 1'b0);
    idle(10, 1'b0);
    chk("ovf_lo", {32'd0, md_lo}, 64'h0000_0000_8000_0000);
    chk("ovf_hi", {32'd0, md_hi}, 64'd0);

    step(MTHI, 32'h12345678, 32'd0, 1'b1);
    step(MFLO, 32'd0, 32'd0, 1'b1);
    step(MFHI, 32'd0, 32'd0, 1'b1);
    chk("mthi", {32'd0, md_hi}, 64'h0000_0000_1234_5678);

    step(MULT, 32'd7, 32'd9, 1'b0);
    idle(2, 1'b0);
    do_reset();
    idle(6, 1'b0);
    chk("abort_lo", {32'd0, md_lo}, 64'd0);

    step(MTHI, 32'd0, 32'd0, 1'b0);
    step(MTLO, 32'd5, 32'd0, 1'b0);
    step(MADD, 32'd2, 32'd3, 1'b1);
    idle(5, 1'b0);
`ifdef MD_SCHED_MADD_EN
    chk("madd_lo", {32'd0, md_lo}, 64'd11);
`else
    chk("madd_off_lo", {32'd0, md_lo}, 64'd5);
`endif

    for (int i = 0; i < 800; i++) begin
      logic [3:0]  op;
      logic [31:0] rs, rt;
      op = ($urandom_range(0, 9) < 3) ? MD_NONE : 4'($urandom_range(0, 15));
      rs = $urandom;
      case ($urandom_range(0, 3))
        0: rt = 32'd0;
        1: rt = $urandom_range(1, 20);
        2: rt = 32'hFFFFFFFF;
        default: rt = $urandom;
      endcase
      step(op, rs, rt, 1'($urandom_range(0, 1)));
    end
    idle(12, 1'b0);
    chk("queue_empty", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
